sr_cmd_driver: RTL and testbench

Command sequencer that sits directly upstream of the W3 SR flip-flop and produces its S/R inputs. It accepts set/clear/toggle/no-op commands over a valid/ready handshake and buffers them in a small FIFO. It replays them as single-cycle, mutually exclusive S or R pulses, with a per-command programmable idle gap. Toggle resolves against the flop's fed-back Q, so the downstream flop never sees S and R high together.

---
 rtl/sr_cmd_pkg.sv | 32 +++
 rtl/sr_cmd_fifo.sv | 55 +++++
 rtl/sr_cmd_driver.sv | 114 +++++++++++
 tb/tb_sr_cmd_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_pkg.sv
// Shared definitions for the SR command sequencer: opcode encodings, FSM
// state encodings, the pulse-counter ceiling and the S/R pulse decode.
package sr_cmd_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_TGL = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_PULSE = 2'd1;
   localparam state_t ST_GAP   = 2'd2;

   localparam logic [7:0] PULSE_CNT_MAX = 8'd255;

   // Map an opcode to {S, R}. A toggle looks at the flop's current Q, so the
   // result is always one-hot or zero and S/R can never both be high.
   function automatic logic [1:0] decode_pulse(input logic [1:0] op, input logic q);
      logic [1:0] sr;
      sr = 2'b00;
      case (op)
         OP_SET:  sr = 2'b10;
         OP_CLR:  sr = 2'b01;
         OP_TGL:  sr = q ? 2'b01 : 2'b10;
         default: sr = 2'b00;
      endcase
      return sr;
   endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// Small synchronous FIFO holding {op, gap} command entries. Pointers carry
// one extra wrap bit so full and empty can be told apart without a counter.
// Read data is the current head entry, valid whenever empty is low.
module sr_cmd_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Storage needs no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Advance write/read pointers independently so a simultaneous push and pop both land.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_cmd_driver.sv
// Command sequencer driving the S/R inputs of a downstream SR flop. Commands
// are queued in a FIFO and replayed as single-cycle, mutually exclusive S or R
// pulses, each followed by its own programmable idle gap.
module sr_cmd_driver
   import sr_cmd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [GAP_W-1:0] cmd_gap,
   input  logic             q_fb,
   output logic             S,
   output logic             R,
   output logic             busy,
   output logic [7:0]       pulse_cnt
);

   localparam int EW = 2 + GAP_W;

   state_t           state;
   logic [GAP_W-1:0] lat_gap;
   logic [GAP_W-1:0] gap_cnt;
   logic [EW-1:0]    fifo_rd_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic [1:0]       head_op;
   logic [GAP_W-1:0] head_gap;

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == ST_IDLE) && !fifo_empty;
   assign head_op   = fifo_rd_data[EW-1:GAP_W];
   assign head_gap  = fifo_rd_data[GAP_W-1:0];
   assign busy      = !fifo_empty || (state != ST_IDLE);

   sr_cmd_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data ({cmd_op, cmd_gap}),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Sequence each command through a one-cycle pulse slot and its idle gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         lat_gap <= '0;
         gap_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  lat_gap <= head_gap;
                  state   <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (lat_gap == '0) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= lat_gap;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               gap_cnt <= gap_cnt - 1'b1;
               if (gap_cnt == GAP_W'(1)) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Register the decoded pulse on the pop edge; it drops on the following edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         S <= 1'b0;
         R <= 1'b0;
      end else if (pop) begin
         {S, R} <= decode_pulse(head_op, q_fb);
      end else begin
         S <= 1'b0;
         R <= 1'b0;
      end
   end

   // Count every non-NOP command popped, sticking at the ceiling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_cnt <= '0;
      end else if (pop && (head_op != OP_NOP) && (pulse_cnt != PULSE_CNT_MAX)) begin
         pulse_cnt <= pulse_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver driving a behavioural SR flop whose Q is
// fed back to q_fb. A negedge monitor logs pulse times, order and resulting Q.
module tb_sr_cmd_driver;
   import sr_cmd_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = OP_NOP;
   logic [3:0] cmd_gap = 4'd0;
   logic       q_flop = 1'b0;
   logic       S;
   logic       R;
   logic       busy;
   logic [7:0] pulse_cnt;

   int n_vec = 0;
   int n_err = 0;

   int cyc = 0;
   int both_cnt = 0;
   int wide_cnt = 0;
   logic s_prev = 1'b0;
   logic r_prev = 1'b0;
   int s_times[$];
   int r_times[$];
   int pulse_seq[$];
   int q_seq[$];

   sr_cmd_driver #(
      .DEPTH (4),
      .GAP_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_gap   (cmd_gap),
      .q_fb      (q_flop),
      .S         (S),
      .R         (R),
      .busy      (busy),
      .pulse_cnt (pulse_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural downstream SR flop.
   always @(posedge clk) begin
      if (S) q_flop <= 1'b1;
      else if (R) q_flop <= 1'b0;
   end

   // Log pulses and the flop state that follows each pulse.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (S && R) both_cnt = both_cnt + 1;
      if ((S && s_prev) || (R && r_prev)) wide_cnt = wide_cnt + 1;
      if (s_prev || r_prev) q_seq.push_back(int'(q_flop));
      if (S) begin
         s_times.push_back(cyc);
         pulse_seq.push_back(1);
      end else if (R) begin
         r_times.push_back(cyc);
         pulse_seq.push_back(0);
      end
      s_prev = S;
      r_prev = R;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] op, input logic [3:0] gap, input int limit);
      bit taken = 1'b0;
      cmd_op    = op;
      cmd_gap   = gap;
      cmd_valid = 1'b1;
      for (int n = 0; n < limit && !taken; n++) begin
         taken = cmd_ready;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      if (!taken) check_output("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int limit);
      for (int n = 0; n < limit && busy; n++) begin
         @(negedge clk);
      end
      if (busy) check_output("idle_timeout", 32'd1, 32'd0);
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      int sb;
      int rb;
      int pb;
      int qb;

      // Reset state
      repeat (2) @(negedge clk);
      check_output("rst_S", S, 0);
      check_output("rst_R", R, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_ready", cmd_ready, 1);
      check_output("rst_cnt", pulse_cnt, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single SET, gap 0: one-cycle S pulse the cycle after acceptance
      apply_stimulus(OP_SET, 4'd0, 5);
      check_output("set_S_early", S, 0);
      check_output("set_busy", busy, 1);
      @(negedge clk);
      check_output("set_S", S, 1);
      check_output("set_R", R, 0);
      check_output("set_cnt", pulse_cnt, 1);
      @(negedge clk);
      check_output("set_S_end", S, 0);
      check_output("set_q", q_flop, 1);
      check_output("set_idle", busy, 0);

      // Fill: a long SET gap holds the FSM so four CLRs fill the FIFO
      rb = r_times.size();
      apply_stimulus(OP_SET, 4'd10, 5);
      for (int i = 0; i < 4; i++) apply_stimulus(OP_CLR, 4'd0, 5);
      check_output("fill_ready", cmd_ready, 0);
      check_output("fill_busy", busy, 1);
      apply_stimulus(OP_CLR, 4'd0, 30);
      wait_idle(100);
      check_output("fill_rcount", r_times.size() - rb, 5);
      if (r_times.size() - rb == 5) begin
         for (int i = 0; i < 4; i++)
            check_output("fill_spacing", r_times[rb+i+1] - r_times[rb+i], 2);
      end
      check_output("fill_cnt", pulse_cnt, 7);
      check_output("fill_q", q_flop, 0);

      // Four toggles from Q=0: S,R,S,R with Q 1,0,1,0
      pb = pulse_seq.size();
      qb = q_seq.size();
      for (int i = 0; i < 4; i++) apply_stimulus(OP_TGL, 4'd0, 10);
      wait_idle(100);
      check_output("tgl_npulses", pulse_seq.size() - pb, 4);
      check_output("tgl_nq", q_seq.size() - qb, 4);
      if (pulse_seq.size() - pb == 4 && q_seq.size() - qb == 4) begin
         for (int i = 0; i < 4; i++) begin
            check_output("tgl_pulse", pulse_seq[pb+i], (i % 2 == 0) ? 1 : 0);
            check_output("tgl_q", q_seq[qb+i], (i % 2 == 0) ? 1 : 0);
         end
      end
      check_output("tgl_cnt", pulse_cnt, 11);

      // SET gap 3, NOP gap 2, CLR: R starts 9 cycles after S
      sb = s_times.size();
      rb = r_times.size();
      apply_stimulus(OP_SET, 4'd3, 10);
      apply_stimulus(OP_NOP, 4'd2, 10);
      apply_stimulus(OP_CLR, 4'd0, 10);
      wait_idle(100);
      check_output("gap_scount", s_times.size() - sb, 1);
      check_output("gap_rcount", r_times.size() - rb, 1);
      if (s_times.size() - sb == 1 && r_times.size() - rb == 1)
         check_output("gap_spacing", r_times[rb] - s_times[sb], 9);
      check_output("gap_cnt", pulse_cnt, 13);

      // Reset in the middle of a gap with three commands queued
      apply_stimulus(OP_SET, 4'd8, 10);
      for (int i = 0; i < 3; i++) apply_stimulus(OP_CLR, 4'd0, 10);
      @(negedge clk);
      check_output("mid_busy", busy, 1);
      check_output("mid_cnt", pulse_cnt, 14);
      sb = s_times.size();
      rb = r_times.size();
      rst = 1'b1;
      #1;
      check_output("arst_S", S, 0);
      check_output("arst_R", R, 0);
      check_output("arst_busy", busy, 0);
      check_output("arst_cnt", pulse_cnt, 0);
      check_output("arst_ready", cmd_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check_output("arst_no_s", s_times.size() - sb, 0);
      check_output("arst_no_r", r_times.size() - rb, 0);
      check_output("arst_idle", busy, 0);

      // 260 SETs: counter saturates at 255
      sb = s_times.size();
      for (int i = 0; i < 260; i++) apply_stimulus(OP_SET, 4'd0, 20);
      wait_idle(100);
      check_output("sat_spulses", s_times.size() - sb, 260);
      check_output("sat_cnt", pulse_cnt, 255);

      // Global pulse properties over the whole run
      check_output("never_both", both_cnt, 0);
      check_output("width_one", wide_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
